// File: rtl/seq_link_pkg.sv
// Shared types and constants for the serial "1010" sync-word link.
// Used by both the transmitter and the detector side of the link.
package seq_link_pkg;

    // Transmitter phases: idle/accept, sync word, payload, forced idle gap.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        DATA = 2'd2,
        GAP  = 2'd3
    } tx_state_e;

    // Default sync pattern of the link, sent MSB-first.
    localparam logic [3:0] SYNC_1010 = 4'b1010;

    // Largest of three lengths; sizes the shared phase counter.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return m;
    endfunction

endpackage

// File: rtl/seq_frame_tx_if.sv
// Valid/ready payload handshake into the serial frame transmitter.
interface seq_frame_tx_if #(
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;

    // Payload source side.
    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    // Transmitter side.
    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );
endinterface

// File: rtl/seq_frame_tx.sv
// Serial frame transmitter: on handshake, sends SYNC_WORD then the payload
// (both MSB-first) on tx_bit, followed by GAP_CYCLES idle cycles.
// tx_bit/tx_active/frame_done are registered from the next state, so the
// first sync bit appears in the cycle right after the accepting edge.
module seq_frame_tx
    import seq_link_pkg::*;
#(
    parameter int                SYNC_W     = 4,
    parameter logic [SYNC_W-1:0] SYNC_WORD  = SYNC_1010,
    parameter int                DATA_W     = 8,
    parameter int                GAP_CYCLES = 2,
    parameter logic              IDLE_LVL   = 1'b0
) (
    input  logic          clk,
    input  logic          rst_n,
    seq_frame_tx_if.slave bus,
    output logic          tx_bit,
    output logic          tx_active,
    output logic          frame_done
);

    // Degenerate frame shapes are rejected at elaboration.
    generate
        if (SYNC_W < 1) begin : g_bad_sync_w
            $fatal(1, "seq_frame_tx: SYNC_W must be >= 1");
        end
        if (DATA_W < 1) begin : g_bad_data_w
            $fatal(1, "seq_frame_tx: DATA_W must be >= 1");
        end
    endgenerate

    // One down-counter serves every phase; it holds (remaining bits - 1).
    localparam int CNT_W = $clog2(max3(SYNC_W, DATA_W, GAP_CYCLES) + 1);
    localparam logic [CNT_W-1:0] SYNC_LOAD = CNT_W'(SYNC_W - 1);
    localparam logic [CNT_W-1:0] DATA_LOAD = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  =
        (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    // Sync word padded to the full counter range so the counter indexes it
    // directly without a width mismatch.
    localparam int               EXT_W    = 1 << CNT_W;
    localparam logic [EXT_W-1:0] SYNC_EXT = EXT_W'(SYNC_WORD);

    tx_state_e         state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [DATA_W-1:0] shift_reg, shift_next;
    logic              tx_bit_reg, tx_bit_next;
    logic              tx_active_reg, tx_active_next;
    logic              frame_done_reg, frame_done_next;

    // Ready only in IDLE, and forced low while reset is held.
    assign bus.in_ready = rst_n && (state_reg == IDLE);

    assign tx_bit     = tx_bit_reg;
    assign tx_active  = tx_active_reg;
    assign frame_done = frame_done_reg;

    // State, phase counter and payload shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            shift_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            shift_reg <= shift_next;
        end
    end

    // Next phase: count each phase down to zero, then move on.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        shift_next = shift_reg;
        case (state_reg)
            IDLE: begin
                if (bus.in_valid) begin
                    state_next = SYNC;
                    cnt_next   = SYNC_LOAD;
                    shift_next = bus.in_data;
                end
            end
            SYNC: begin
                if (cnt_reg == '0) begin
                    state_next = DATA;
                    cnt_next   = DATA_LOAD;
                end else begin
                    cnt_next = cnt_reg - CNT_ONE;
                end
            end
            DATA: begin
                if (cnt_reg == '0) begin
                    if (GAP_CYCLES > 0) begin
                        state_next = GAP;
                        cnt_next   = GAP_LOAD;
                    end else begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end
                end else begin
                    // Payload MSB is always the bit on the line in DATA.
                    cnt_next   = cnt_reg - CNT_ONE;
                    shift_next = shift_reg << 1;
                end
            end
            GAP: begin
                if (cnt_reg == '0) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg - CNT_ONE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
                shift_next = '0;
            end
        endcase
    end

    // Line values for the phase being entered; registered below.
    always_comb begin
        tx_bit_next     = IDLE_LVL;
        tx_active_next  = 1'b0;
        frame_done_next = 1'b0;
        case (state_next)
            SYNC: begin
                tx_bit_next    = SYNC_EXT[cnt_next];
                tx_active_next = 1'b1;
            end
            DATA: begin
                tx_bit_next     = shift_next[DATA_W-1];
                tx_active_next  = 1'b1;
                frame_done_next = (cnt_next == '0);
            end
            default: begin
                tx_bit_next     = IDLE_LVL;
                tx_active_next  = 1'b0;
                frame_done_next = 1'b0;
            end
        endcase
    end

    // Registered serial outputs; reset drops any frame in flight at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_bit_reg     <= IDLE_LVL;
            tx_active_reg  <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            tx_bit_reg     <= tx_bit_next;
            tx_active_reg  <= tx_active_next;
            frame_done_reg <= frame_done_next;
        end
    end

endmodule

// File: tb/tb_seq_frame_tx.sv
// Testbench for seq_frame_tx: directed and random frames against a
// queue-based model of the line, plus a GAP_CYCLES=0 / DATA_W=1 instance.
module tb_seq_frame_tx;
    import seq_link_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic tx_bit, tx_active, frame_done;
    logic tx_bit2, tx_active2, frame_done2;

    seq_frame_tx_if #(.DATA_W(8)) bus ();
    seq_frame_tx_if #(.DATA_W(1)) bus2 ();

    seq_frame_tx dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .tx_bit     (tx_bit),
        .tx_active  (tx_active),
        .frame_done (frame_done)
    );

    seq_frame_tx #(
        .DATA_W     (1),
        .GAP_CYCLES (0)
    ) dut2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus2),
        .tx_bit     (tx_bit2),
        .tx_active  (tx_active2),
        .frame_done (frame_done2)
    );

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int since_acc  = 0;
    int last_gap   = 0;

    // Line model: one slot per cycle still owed by accepted frames.
    typedef struct packed {
        logic b;
        logic act;
        logic done;
    } slot_t;
    slot_t q[$];
    logic exp_b, exp_act, exp_done, exp_ready;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    // A frame is the 1010 sync word, 8 payload bits MSB-first, 2 gap cycles.
    task automatic push_frame(input logic [7:0] d);
        logic [3:0] sw;
        sw = 4'b1010;
        for (int i = 3; i >= 0; i--) q.push_back('{b: sw[i], act: 1'b1, done: 1'b0});
        for (int i = 7; i >= 0; i--) q.push_back('{b: d[i], act: 1'b1, done: (i == 0)});
        for (int i = 0; i < 2; i++) q.push_back('{b: 1'b0, act: 1'b0, done: 1'b0});
    endtask

    // One clock: apply the handshake to the model, then check all outputs.
    task automatic tick();
        logic hs;
        slot_t s;
        @(posedge clk);
        hs = rst_n && bus.in_valid && exp_ready;
        if (hs) begin
            push_frame(bus.in_data);
            last_gap  = since_acc;
            since_acc = 0;
        end
        #1;
        cyc++;
        since_acc++;
        if (!rst_n) begin
            q.delete();
            {exp_b, exp_act, exp_done, exp_ready} = 4'b0000;
        end else if (q.size() > 0) begin
            s = q.pop_front();
            {exp_b, exp_act, exp_done} = {s.b, s.act, s.done};
            exp_ready = 1'b0;
        end else begin
            {exp_b, exp_act, exp_done} = 3'b000;
            exp_ready = 1'b1;
        end
        chk("tx_bit", 32'(tx_bit), 32'(exp_b));
        chk("tx_active", 32'(tx_active), 32'(exp_act));
        chk("frame_done", 32'(frame_done), 32'(exp_done));
        chk("in_ready", 32'(bus.in_ready), 32'(exp_ready));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] d;
        logic [5:0] e5b, e5a, e5d, e5r;
        logic       hist[1:20];
        int         hits[$];

        rst_n = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus2.in_valid = 1'b0;
        bus2.in_data  = '0;
        exp_ready = 1'b0;

        // 1: reset held 3 cycles, then 10 idle cycles.
        repeat (3) tick();
        rst_n = 1'b1;
        exp_ready = 1'b1;
        #1 chk("ready_after_release", 32'(bus.in_ready), 32'd1);
        repeat (10) tick();

        // 2: single frame C3.
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hC3;
        tick();
        bus.in_valid = 1'b0;
        repeat (15) begin
            bus.in_data = 8'($urandom);
            tick();
        end

        // 3: back-to-back A5 then 5A, junk on in_data until the second accept.
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hA5;
        tick();
        repeat (13) begin
            bus.in_data = 8'($urandom);
            tick();
        end
        bus.in_data = 8'h5A;
        tick();
        tick();
        chk("b2b_accept_cycle", 32'(last_gap), 32'd15);
        bus.in_valid = 1'b0;
        repeat (16) tick();

        // 4: reset during the 2nd data bit.
        d = 8'($urandom) | 8'h40;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        tick();
        bus.in_valid = 1'b0;
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        chk("rst_tx_bit", 32'(tx_bit), 32'd0);
        chk("rst_tx_active", 32'(tx_active), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        q.delete();
        exp_ready = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        exp_ready = 1'b1;
        #1 chk("ready_after_midreset", 32'(bus.in_ready), 32'd1);
        repeat (20) tick();

        // 6: loopback into a 1010 Moore detector, payload 0A.
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h0A;
        tick();
        hist[1] = tx_bit;
        bus.in_valid = 1'b0;
        for (int k = 2; k <= 20; k++) begin
            tick();
            hist[k] = tx_bit;
        end
        for (int k = 5; k <= 20; k++) begin
            if ({hist[k-4], hist[k-3], hist[k-2], hist[k-1]} == 4'b1010) hits.push_back(k);
        end
        chk("det_pulses", 32'(hits.size()), 32'd2);
        if (hits.size() == 2) begin
            chk("det_first", 32'(hits[0]), 32'd5);
            chk("det_second", 32'(hits[1]), 32'd13);
        end

        // Random traffic against the model.
        repeat (300) begin
            bus.in_valid = ($urandom_range(0, 3) != 0);
            bus.in_data  = 8'($urandom);
            tick();
        end
        bus.in_valid = 1'b0;
        repeat (16) tick();

        // 5: DATA_W=1, GAP_CYCLES=0 instance, in_data=1 held valid.
        e5b = 6'b101010;
        e5a = 6'b111110;
        e5d = 6'b000010;
        e5r = 6'b000001;
        chk("g0_ready_idle", 32'(bus2.in_ready), 32'd1);
        bus2.in_data  = 1'b1;
        bus2.in_valid = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 6; k++) begin
            #1;
            chk("g0_tx_bit", 32'(tx_bit2), 32'(e5b[6-k]));
            chk("g0_tx_active", 32'(tx_active2), 32'(e5a[6-k]));
            chk("g0_frame_done", 32'(frame_done2), 32'(e5d[6-k]));
            chk("g0_in_ready", 32'(bus2.in_ready), 32'(e5r[6-k]));
            @(posedge clk);
        end
        #1;
        chk("g0_next_sync_bit", 32'(tx_bit2), 32'd1);
        chk("g0_next_active", 32'(tx_active2), 32'd1);
        bus2.in_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
